icache: RTL



---
 rtl/icache_pkg.sv | 10 +
 rtl/icache_array.sv | 35 +++
 rtl/icache.sv | 112 +++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM states, default geometry and I/O region decode for the instruction cache
package icache_pkg;
  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;
  localparam int INDEX_W_DEF = 7;
  localparam int ADDR_W_DEF = 18;
  localparam logic [1:0] IO_REGION = 2'b11;
  function automatic int tag_width(input int addr_w, input int index_w);
    return addr_w - index_w - 2;
  endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: tag/valid/data storage with combinational read and one synchronous write port
import icache_pkg::*;
module icache_array #(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int TAG_W = tag_width(ADDR_W_DEF, INDEX_W_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);
  localparam int LINES = 1 << INDEX_W;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx];
  // valid bits are the only storage cleared by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  // tag and data are meaningless until valid is set, so they carry no reset
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-line instruction cache; ICACHE_STATS_EN adds hit/miss counters
import icache_pkg::*;
module icache #(
  parameter int INDEX_W = INDEX_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_done_in,
  input  logic [31:0] mem_inst_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out
`endif
);
  localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
  state_t state, state_n;
  logic inst_valid_n, mem_req_n, fill, we, lookup, hit, io_line, rd_valid;
  logic [31:0] inst_n, mem_addr_n, rd_data;
  logic [TAG_W-1:0] rd_tag;
  logic unused_bits;
  assign unused_bits = &{1'b0, if_addr_in[1:0]};
  assign lookup = state == IDLE && if_req_in && !flush_in && !inst_valid_out;
  assign hit = rd_valid && rd_tag == if_addr_in[ADDR_W-1:INDEX_W+2];
  assign io_line = mem_addr_out[ADDR_W-1 -: 2] == IO_REGION;
  assign we = fill && rdy_in && !io_line;
  icache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk(clk_in),
    .rst_n(rst_in),
    .rd_idx(if_addr_in[INDEX_W+1:2]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .we(we),
    .wr_idx(mem_addr_out[INDEX_W+1:2]),
    .wr_tag(mem_addr_out[ADDR_W-1:INDEX_W+2]),
    .wr_data(mem_inst_in)
  );
  // next-state: lookup in IDLE, refill completion in MISS/DROP, flush turns MISS into DROP
  always_comb begin
    state_n = state;
    inst_valid_n = 1'b0;
    inst_n = inst_out;
    mem_req_n = mem_req_out;
    mem_addr_n = mem_addr_out;
    fill = 1'b0;
    case (state)
      IDLE:
        if (lookup && hit) begin
          inst_valid_n = 1'b1;
          inst_n = rd_data;
        end else if (lookup) begin
          state_n = MISS;
          mem_req_n = 1'b1;
          mem_addr_n = {if_addr_in[31:2], 2'b00};
        end
      MISS:
        if (mem_done_in) begin
          fill = 1'b1;
          mem_req_n = 1'b0;
          state_n = IDLE;
          inst_valid_n = !flush_in;
          inst_n = flush_in ? inst_out : mem_inst_in;
        end else if (flush_in) state_n = DROP;
      DROP:
        if (mem_done_in) begin
          fill = 1'b1;
          mem_req_n = 1'b0;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  // registers advance only while the pipeline is ready
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      inst_valid_out <= 1'b0;
      inst_out <= '0;
      mem_req_out <= 1'b0;
      mem_addr_out <= '0;
    end else if (rdy_in) begin
      state <= state_n;
      inst_valid_out <= inst_valid_n;
      inst_out <= inst_n;
      mem_req_out <= mem_req_n;
      mem_addr_out <= mem_addr_n;
    end
`ifdef ICACHE_STATS_EN
  logic hit_evt, miss_evt;
  assign hit_evt = lookup && hit;
  assign miss_evt = lookup && !hit;
  // free-running wrap-around event counters
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      hit_cnt_out <= '0;
      miss_cnt_out <= '0;
    end else if (rdy_in) begin
      hit_cnt_out <= hit_cnt_out + 32'(hit_evt);
      miss_cnt_out <= miss_cnt_out + 32'(miss_evt);
    end
`endif
endmodule
